write_stream: RTL and testbench

WRITE_STREAM -- requirements
Module: write_stream

---
 rtl/write_stream_if.sv | 39 +++
 rtl/write_stream.sv | 132 +++++++++++++
 tb/tb_write_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_stream_if.sv
// AXI4 write channels (AW, W, B) between a burst master and a memory-side slave.
// Uppercase member names follow the AXI signal names used on the bus.
interface write_stream_if;
  logic         AWREADY;
  logic         AWVALID;
  logic [31:0]  AWADDR;
  logic [3:0]   AWID;
  logic [7:0]   AWLEN;
  logic [2:0]   AWSIZE;
  logic [1:0]   AWBURST;
  logic [1:0]   AWLOCK;
  logic [3:0]   AWCACHE;
  logic [2:0]   AWPROT;

  logic         WREADY;
  logic         WVALID;
  logic [511:0] WDATA;
  logic [63:0]  WSTRB;
  logic         WLAST;

  logic         BREADY;
  logic         BVALID;
  logic [3:0]   BID;
  logic [1:0]   BRESP;

  modport master (
    input  AWREADY, WREADY, BVALID, BID, BRESP,
    output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
    output WVALID, WDATA, WSTRB, WLAST,
    output BREADY
  );

  modport slave (
    output AWREADY, WREADY, BVALID, BID, BRESP,
    input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
    input  WVALID, WDATA, WSTRB, WLAST,
    input  BREADY
  );
endinterface

// File: rtl/write_stream.sv
// AXI4 incrementing write-burst generator; WRITE_STREAM_ERRCNT_EN enables the BRESP error counter.
// Latency: AW one cycle after en is seen idle, W beats after the AW handshake, finish on the accepted B.
// Backpressure: AWVALID/WVALID and payload hold until AWREADY/WREADY; BREADY only while awaiting the response.
module write_stream #(
  parameter logic [63:0] WSTRB_VAL = {64{1'b1}}
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [31:0]    addr,
  input  logic [7:0]     burst_length,
  output logic           busy,
  output logic           finish,
  output logic [15:0]    err_count,
  write_stream_if.master axi
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_r;
  logic [7:0]  len_r;
  logic [7:0]  beat;
  logic [7:0]  awlen;
  logic [3:0]  id_r;
  logic [31:0] word;
  logic        last_beat;
  logic        relatch;
  logic        aw_hs;
  logic        w_hs;

  assign awlen     = len_r - 8'd1;
  assign last_beat = (beat == awlen);
  assign aw_hs     = axi.AWVALID && axi.AWREADY;
  assign w_hs      = axi.WVALID && axi.WREADY;
  assign busy      = (state != S_IDLE);

  // Handshake outputs are qualified by reset_n so nothing completes on the reset edge.
  always_comb begin
    state_nxt  = state;
    relatch    = 1'b0;
    axi.AWVALID = 1'b0;
    axi.WVALID  = 1'b0;
    axi.WLAST   = 1'b0;
    axi.BREADY  = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          relatch   = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        axi.AWVALID = reset_n;
        if (axi.AWREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        axi.WVALID = reset_n;
        axi.WLAST  = reset_n && last_beat;
        if (axi.WREADY && last_beat) state_nxt = S_RESP;
      end
      S_RESP: begin
        axi.BREADY = reset_n;
        finish     = reset_n && axi.BVALID;
        if (axi.BVALID) begin
          relatch   = en;
          state_nxt = en ? S_ADDR : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      addr_r <= '0;
      len_r  <= '0;
      id_r   <= '0;
      beat   <= '0;
    end else begin
      state <= state_nxt;
      if (relatch) begin
        addr_r <= addr;
        len_r  <= burst_length;
      end
      if (aw_hs) begin
        id_r <= id_r + 4'd1;
        beat <= '0;
      end else if (w_hs) begin
        beat <= beat + 8'd1;
      end
    end
  end

  // Each beat carries its own 64-byte-aligned address replicated across the bus.
  assign word = addr_r + {18'd0, beat, 6'd0};

  assign axi.AWADDR  = addr_r;
  assign axi.AWID    = id_r;
  assign axi.AWLEN   = awlen;
  assign axi.AWSIZE  = 3'b110;
  assign axi.AWBURST = 2'b01;
  assign axi.AWLOCK  = 2'b00;
  assign axi.AWCACHE = 4'b0000;
  assign axi.AWPROT  = 3'b000;
  assign axi.WDATA   = {16{word}};
  assign axi.WSTRB   = WSTRB_VAL;

`ifdef WRITE_STREAM_ERRCNT_EN
  logic [15:0] err_r;
  logic        unused_bid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_r <= '0;
    end else if (axi.BVALID && axi.BREADY && (axi.BRESP != 2'b00) && (err_r != 16'hFFFF)) begin
      err_r <= err_r + 16'd1;
    end
  end

  assign err_count  = err_r;
  assign unused_bid = ^axi.BID;
`else
  logic unused_b;

  assign err_count = '0;
  assign unused_b  = ^{axi.BID, axi.BRESP};
`endif

endmodule

// File: tb/tb_write_stream.sv
// Scoreboard bench for write_stream: AW/W expectations queued at issue, checked on handshakes.
module tb_write_stream;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } aw_exp_t;

  typedef struct packed {
    logic [31:0] word;
    logic        last;
  } w_exp_t;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic [31:0] addr;
  logic [7:0]  burst_length;
  logic        busy;
  logic        finish;
  logic [15:0] err_count;

  write_stream_if axi ();

  write_stream dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .addr         (addr),
    .burst_length (burst_length),
    .busy         (busy),
    .finish       (finish),
    .err_count    (err_count),
    .axi          (axi)
  );

  aw_exp_t     aw_q[$];
  w_exp_t      w_q[$];
  aw_exp_t     aw_e;
  w_exp_t      w_e;
  int          passed;
  int          total;
  logic [3:0]  exp_id;
  logic [15:0] exp_err;

  logic         awv_p, wv_p, aw_seen;
  logic [31:0]  awaddr_p;
  logic [7:0]   awlen_p;
  logic [3:0]   awid_p;
  logic [511:0] wdata_p;
  logic         wlast_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: stability of stalled payloads and scoreboard pops.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      awv_p   = 1'b0;
      wv_p    = 1'b0;
      aw_seen = 1'b0;
    end else begin
      if (awv_p) begin
        total++;
        if (axi.AWVALID !== 1'b1 || axi.AWADDR !== awaddr_p || axi.AWLEN !== awlen_p || axi.AWID !== awid_p)
          $display("FAIL aw_stable: got valid=%b addr=%h len=%0d id=%0d, held addr=%h len=%0d id=%0d",
                   axi.AWVALID, axi.AWADDR, axi.AWLEN, axi.AWID, awaddr_p, awlen_p, awid_p);
        else passed++;
      end
      if (wv_p) begin
        total++;
        if (axi.WVALID !== 1'b1 || axi.WDATA !== wdata_p || axi.WLAST !== wlast_p)
          $display("FAIL w_stable: got valid=%b last=%b word=%h, held last=%b word=%h",
                   axi.WVALID, axi.WLAST, axi.WDATA[31:0], wlast_p, wdata_p[31:0]);
        else passed++;
      end
      if (axi.AWVALID === 1'b1 && axi.AWREADY === 1'b1) begin
        total++;
        if (aw_q.size() == 0) begin
          $display("FAIL aw_unexpected: addr=%h len=%0d id=%0d, expected no AW", axi.AWADDR, axi.AWLEN, axi.AWID);
        end else begin
          aw_e = aw_q.pop_front();
          if (axi.AWADDR !== aw_e.addr || axi.AWLEN !== aw_e.len || axi.AWID !== aw_e.id)
            $display("FAIL aw_payload: got addr=%h len=%0d id=%0d, expected addr=%h len=%0d id=%0d",
                     axi.AWADDR, axi.AWLEN, axi.AWID, aw_e.addr, aw_e.len, aw_e.id);
          else passed++;
        end
        aw_seen = 1'b1;
      end
      if (axi.WVALID === 1'b1 && axi.WREADY === 1'b1) begin
        total++;
        if (!aw_seen) begin
          $display("FAIL w_before_aw: beat word=%h issued with no AW handshake", axi.WDATA[31:0]);
        end else if (w_q.size() == 0) begin
          $display("FAIL w_unexpected: word=%h last=%b, expected no beat", axi.WDATA[31:0], axi.WLAST);
        end else begin
          w_e = w_q.pop_front();
          if (axi.WDATA !== {16{w_e.word}} || axi.WLAST !== w_e.last)
            $display("FAIL w_beat: got data=%h last=%b, expected 16x%h last=%b",
                     axi.WDATA, axi.WLAST, w_e.word, w_e.last);
          else passed++;
        end
        if (axi.WLAST === 1'b1) aw_seen = 1'b0;
      end
      awv_p    = (axi.AWVALID === 1'b1) && (axi.AWREADY !== 1'b1);
      awaddr_p = axi.AWADDR;
      awlen_p  = axi.AWLEN;
      awid_p   = axi.AWID;
      wv_p     = (axi.WVALID === 1'b1) && (axi.WREADY !== 1'b1);
      wdata_p  = axi.WDATA;
      wlast_p  = axi.WLAST;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [7:0] len);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    en           = 1'b1;
    addr         = a;
    burst_length = len;
    aw_q.push_back(aw_exp_t'{addr: a, len: len - 8'd1, id: exp_id});
    exp_id = exp_id + 4'd1;
    for (int b = 0; b < n; b++)
      w_q.push_back(w_exp_t'{word: a + 32'(b) * 32'd64, last: (b == n - 1)});
  endtask

  // Drives slave readiness plus noise on en/addr/len/BVALID until the queues drain to stop_left beats.
  task automatic serve(input int aw_stall, input bit w_toggle, input int stop_left);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      if (w_q.size() <= stop_left && aw_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      axi.AWREADY  = (cyc >= aw_stall);
      axi.WREADY   = w_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      en           = 1'($urandom_range(0, 1));
      addr         = $urandom;
      burst_length = 8'($urandom);
      axi.BVALID   = 1'($urandom_range(0, 1));
      axi.BRESP    = 2'b10;
      #1;
      total++;
      if (finish !== 1'b0 || axi.BREADY !== 1'b0 || busy !== 1'b1)
        $display("FAIL in_burst: finish=%b bready=%b busy=%b, expected 0 0 1", finish, axi.BREADY, busy);
      else passed++;
    end
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    if (!done) begin
      total++;
      $display("FAIL serve_timeout: aw left=%0d w left=%0d, expected %0d w left", aw_q.size(), w_q.size(), stop_left);
      aw_q.delete();
      w_q.delete();
    end
  endtask

  task automatic respond(input logic [1:0] resp, input bit en_next);
    axi.BVALID = 1'b1;
    axi.BRESP  = resp;
    axi.BID    = exp_id - 4'd1;
    en         = en_next;
    @(negedge clk);
    total++;
    if (finish !== 1'b1 || axi.BREADY !== 1'b1)
      $display("FAIL finish_pulse: finish=%b bready=%b, expected 1 1", finish, axi.BREADY);
    else passed++;
    @(posedge clk); #1;
`ifdef WRITE_STREAM_ERRCNT_EN
    if (resp != 2'b00) exp_err = exp_err + 16'd1;
`endif
    total++;
    if (busy !== en_next || axi.AWVALID !== en_next)
      $display("FAIL after_resp: busy=%b awvalid=%b, expected %b %b", busy, axi.AWVALID, en_next, en_next);
    else passed++;
    total++;
    if (err_count !== exp_err)
      $display("FAIL err_count: got %0d, expected %0d", err_count, exp_err);
    else passed++;
    axi.BVALID = 1'b0;
    axi.BRESP  = 2'b00;
    @(negedge clk);
    total++;
    if (finish !== 1'b0)
      $display("FAIL finish_one_cycle: finish=%b, expected 0", finish);
    else passed++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    en      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, finish, axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY} !== 6'b0)
      $display("FAIL reset_outputs: busy/finish/awv/wv/wlast/bready=%b, expected 000000",
               {busy, finish, axi.AWVALID, axi.WVALID, axi.WLAST, axi.BREADY});
    else passed++;
    total++;
    if (err_count !== 16'd0) $display("FAIL reset_err_count: got %0d, expected 0", err_count);
    else passed++;
    total++;
    if (axi.AWSIZE !== 3'b110 || axi.AWBURST !== 2'b01 || axi.AWLOCK !== 2'b00 ||
        axi.AWCACHE !== 4'b0 || axi.AWPROT !== 3'b0 || axi.WSTRB !== {64{1'b1}})
      $display("FAIL aw_constants: size=%b burst=%b lock=%b cache=%b prot=%b strb=%h, expected 110 01 00 0000 000 all-ones",
               axi.AWSIZE, axi.AWBURST, axi.AWLOCK, axi.AWCACHE, axi.AWPROT, axi.WSTRB);
    else passed++;
    aw_q.delete();
    w_q.delete();
    exp_id  = 4'd0;
    exp_err = 16'd0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, expected 0", busy);
    else passed++;
  endtask

  task automatic test_basic;
    issue(32'h0000_1000, 8'd4);
    serve(0, 1'b0, 0);
    respond(2'b00, 1'b0);
  endtask

  task automatic test_bvalid_idle;
    en         = 1'b0;
    axi.BVALID = 1'b1;
    axi.BRESP  = 2'b11;
    @(negedge clk);
    total++;
    if (finish !== 1'b0 || axi.BREADY !== 1'b0)
      $display("FAIL bvalid_idle: finish=%b bready=%b, expected 0 0", finish, axi.BREADY);
    else passed++;
    @(posedge clk); #1;
    axi.BVALID = 1'b0;
    axi.BRESP  = 2'b00;
    total++;
    if (busy !== 1'b0 || err_count !== exp_err)
      $display("FAIL bvalid_idle_state: busy=%b err=%0d, expected 0 %0d", busy, err_count, exp_err);
    else passed++;
  endtask

  task automatic test_long_burst;
    issue(32'hFFFF_F000, 8'd0);
    serve(0, 1'b1, 0);
    respond(2'b00, 1'b0);
  endtask

  task automatic test_stall;
    issue(32'hABCD_0040, 8'd8);
    serve(5, 1'b1, 0);
    respond(2'b00, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] want;
`ifdef WRITE_STREAM_ERRCNT_EN
    want = 16'd2;
`else
    want = 16'd0;
`endif
    test_reset();
    issue(32'h0000_4000, 8'd3);
    serve(0, 1'b0, 0);
    issue(32'h0001_0000, 8'd2);
    respond(2'b10, 1'b1);
    serve(2, 1'b1, 0);
    issue(32'h0002_0000, 8'd5);
    respond(2'b00, 1'b1);
    serve(0, 1'b1, 0);
    respond(2'b10, 1'b0);
    total++;
    if (err_count !== want || busy !== 1'b0)
      $display("FAIL b2b_final: err=%0d busy=%b, expected %0d 0", err_count, busy, want);
    else passed++;
  endtask

  task automatic test_reset_mid;
    issue(32'h0005_0000, 8'd8);
    serve(0, 1'b0, 6);
    reset_n = 1'b0;
    en      = 1'b0;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    @(posedge clk); #1;
    total++;
    if (axi.WVALID !== 1'b0 || busy !== 1'b0 || axi.AWVALID !== 1'b0)
      $display("FAIL reset_abort: wvalid=%b busy=%b awvalid=%b, expected 0 0 0", axi.WVALID, busy, axi.AWVALID);
    else passed++;
    aw_q.delete();
    w_q.delete();
    exp_id  = 4'd0;
    exp_err = 16'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || err_count !== 16'd0)
      $display("FAIL post_reset_idle: busy=%b err=%0d, expected 0 0", busy, err_count);
    else passed++;
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    issue(32'h0006_0000, 8'd2);
    serve(0, 1'b0, 0);
    respond(2'b00, 1'b0);
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    exp_id       = 4'd0;
    exp_err      = 16'd0;
    reset_n      = 1'b0;
    en           = 1'b0;
    addr         = '0;
    burst_length = '0;
    axi.AWREADY  = 1'b0;
    axi.WREADY   = 1'b0;
    axi.BVALID   = 1'b0;
    axi.BID      = 4'd0;
    axi.BRESP    = 2'b00;

    test_reset();
    test_basic();
    test_bvalid_idle();
    test_long_burst();
    test_stall();
    test_back_to_back();
    test_reset_mid();

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (aw_q.size() != 0 || w_q.size() != 0)
      $display("FAIL drained: aw left=%0d w left=%0d, expected 0 0", aw_q.size(), w_q.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
